char_stream_arb: RTL and testbench



---
 rtl/char_stream_arb.sv | 204 ++++++++++++++++++++
 tb/tb_char_stream_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_stream_arb.sv
// char_stream_arb
// Two-requester arbiter/sequencer for the shared character recognizer.
// Accepts a whole string from one requester at a time and clears the
// recognizer before the first character. It then feeds one character per
// strobe and reports the recognizer verdict with the source and the length.
//
// Optional feature: define CHAR_STREAM_ARB_RR_EN for round-robin arbitration.
// When the macro is undefined, requester 0 has fixed priority.

module char_stream_arb #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_char,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_char,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic [7:0]       fsm_char,
    output logic             fsm_en,
    output logic             fsm_clr,
    input  logic             fsm_out,
    output logic             res_valid,
    output logic             res_src,
    output logic             res_match,
    output logic [LEN_W-1:0] res_len
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             grant;
    logic             grant_nxt;
    logic             arb_pick;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_char;
    logic             xfer;
    logic [LEN_W-1:0] len_cnt;
    logic             match_q;

`ifdef CHAR_STREAM_ARB_RR_EN
    logic             prio;
`endif

    // Route the granted requester's handshake signals to a single set
    always_comb begin
        sel_valid = req0_valid;
        sel_char  = req0_char;
        sel_last  = req0_last;
        if (grant) begin
            sel_valid = req1_valid;
            sel_char  = req1_char;
            sel_last  = req1_last;
        end
    end

    // Ready goes only to the owner of the current string, and only while streaming
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == STREAM) begin
            req0_ready = ~grant;
            req1_ready = grant;
        end
        xfer = (state == STREAM) && sel_valid;
    end

`ifdef CHAR_STREAM_ARB_RR_EN
    // Round-robin pick: on a tie the source that did not finish last wins
    always_comb begin
        arb_pick = ~req0_valid;
        if (req0_valid && req1_valid) begin
            arb_pick = prio;
        end
    end

    // The priority pointer flips away from whichever source just reported
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (state == REPORT) begin
            prio <= ~grant;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle
    always_comb begin
        arb_pick = ~req0_valid;
    end
`endif

    // Next-state logic; the grant is latched only when leaving IDLE
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_nxt = arb_pick;
                    state_nxt = CLR;
                end
            end
            CLR: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (xfer && sel_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = REPORT;
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and grant registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Registered strobe to the recognizer; the character is held when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_char <= 8'h00;
            fsm_en   <= 1'b0;
            fsm_clr  <= 1'b0;
        end else begin
            fsm_en  <= xfer;
            fsm_clr <= (state_nxt == CLR);
            if (xfer) begin
                fsm_char <= sel_char;
            end
        end
    end

    // Per-string character counter, cleared in CLR and saturating at all ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_cnt <= '0;
        end else if (state == CLR) begin
            len_cnt <= '0;
        end else if (xfer && (len_cnt != {LEN_W{1'b1}})) begin
            len_cnt <= len_cnt + LEN_W'(1);
        end
    end

    // Result fields load on entry to REPORT so they are stable with the pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_src   <= 1'b0;
            res_len   <= '0;
        end else begin
            res_valid <= (state == DRAIN);
            if (state == DRAIN) begin
                res_src <= grant;
                res_len <= len_cnt;
            end
        end
    end

    // Verdict is latched at the end of REPORT, once the last character has settled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q <= 1'b0;
        end else if (state == REPORT) begin
            match_q <= fsm_out;
        end
    end

    // During REPORT the live verdict is shown so it lines up with res_valid
    always_comb begin
        res_match = match_q;
        if (state == REPORT) begin
            res_match = fsm_out;
        end
    end

endmodule

// File: tb/tb_char_stream_arb.sv
// tb_char_stream_arb
// Directed bench for char_stream_arb with a small recognizer model that
// flags any string containing the substring "cd".
// Optional feature: CHAR_STREAM_ARB_RR_EN selects round-robin expectations.

`timescale 1ns/1ps

module tb_char_stream_arb;

    localparam int LEN_W = 5;

    logic             clk;
    logic             reset_n;
    logic             req0_valid;
    logic [7:0]       req0_char;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_char;
    logic             req1_last;
    logic             req1_ready;
    logic [7:0]       fsm_char;
    logic             fsm_en;
    logic             fsm_clr;
    logic             fsm_out;
    logic             res_valid;
    logic             res_src;
    logic             res_match;
    logic [LEN_W-1:0] res_len;

    int err_count;
    int check_count;
    int cycle;

    byte en_char_q[$];
    int  en_cyc_q[$];
    int  clr_cyc_q[$];
    int  res_src_q[$];
    int  res_match_q[$];
    int  res_len_q[$];
    int  res_cyc_q[$];
    int  first_r1_cyc;

    logic model_prev_c;
    logic model_out;

    char_stream_arb #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_char  (req0_char),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_char  (req1_char),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .fsm_char   (fsm_char),
        .fsm_en     (fsm_en),
        .fsm_clr    (fsm_clr),
        .fsm_out    (fsm_out),
        .res_valid  (res_valid),
        .res_src    (res_src),
        .res_match  (res_match),
        .res_len    (res_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Recognizer model: verdict sets once "cd" has been consumed
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_prev_c <= 1'b0;
            model_out    <= 1'b0;
        end else if (fsm_clr) begin
            model_prev_c <= 1'b0;
            model_out    <= 1'b0;
        end else if (fsm_en) begin
            model_out    <= model_out | (model_prev_c && (fsm_char == "d"));
            model_prev_c <= (fsm_char == "c");
        end
    end
    assign fsm_out = model_out;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor records strobes and results away from the active edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (fsm_en) begin
                en_char_q.push_back(fsm_char);
                en_cyc_q.push_back(cycle);
            end
            if (fsm_clr) clr_cyc_q.push_back(cycle);
            if (res_valid) begin
                res_src_q.push_back(int'(res_src));
                res_match_q.push_back(int'(res_match));
                res_len_q.push_back(int'(res_len));
                res_cyc_q.push_back(cycle);
            end
            if (req1_ready && first_r1_cyc < 0) first_r1_cyc = cycle;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        en_char_q.delete();
        en_cyc_q.delete();
        clr_cyc_q.delete();
        res_src_q.delete();
        res_match_q.delete();
        res_len_q.delete();
        res_cyc_q.delete();
        first_r1_cyc = -1;
    endtask

    task automatic driveSrc(input int src, input logic v, input byte c, input logic l);
        if (src == 0) begin
            req0_valid = v; req0_char = c; req0_last = l;
        end else begin
            req1_valid = v; req1_char = c; req1_last = l;
        end
    endtask

    // Streams one string from a source; optionally drops valid for gap_len cycles before index gap_at
    task automatic applyStimulus(input int src, input string s, input int gap_at, input int gap_len);
        int t;
        logic rdy;
        for (int i = 0; i < s.len(); i++) begin
            if (i == gap_at) begin
                driveSrc(src, 1'b0, s[i-1], 1'b0);
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    checkOutput("gap_en", fsm_en, 1'b0);
                    checkOutput("gap_char", fsm_char, s[i-1]);
                end
            end
            driveSrc(src, 1'b1, s[i], (i == s.len() - 1));
            t = 0;
            rdy = (src == 0) ? req0_ready : req1_ready;
            while (!rdy && t < 300) begin
                @(negedge clk);
                t++;
                rdy = (src == 0) ? req0_ready : req1_ready;
            end
            if (!rdy) begin
                checkOutput("ready_timeout", 0, 1);
                driveSrc(src, 1'b0, 8'h00, 1'b0);
                return;
            end
            @(negedge clk);
        end
        driveSrc(src, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic waitResults(input int n);
        int t;
        t = 0;
        while (res_src_q.size() < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checkOutput("result_count", res_src_q.size(), n);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_fsm_char"}, fsm_char, 8'h00);
        checkOutput({tag, "_fsm_en"}, fsm_en, 1'b0);
        checkOutput({tag, "_fsm_clr"}, fsm_clr, 1'b0);
        checkOutput({tag, "_res_valid"}, res_valid, 1'b0);
        checkOutput({tag, "_res_src"}, res_src, 1'b0);
        checkOutput({tag, "_res_match"}, res_match, 1'b0);
        checkOutput({tag, "_res_len"}, res_len, 0);
        checkOutput({tag, "_req0_ready"}, req0_ready, 1'b0);
        checkOutput({tag, "_req1_ready"}, req1_ready, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        string long_s;
        int    bad;
        int    t;
        err_count    = 0;
        check_count  = 0;
        cycle        = 0;
        first_r1_cyc = -1;
        reset_n      = 1'b0;
        driveSrc(0, 1'b0, 8'h00, 1'b0);
        driveSrc(1, 1'b0, 8'h00, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Reset mid-string after two of four characters
        clearLog();
        req0_valid = 1'b1; req0_char = "w"; req0_last = 1'b0;
        t = 0;
        while (!req0_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("midrst_ready", req0_ready, 1'b1);
        @(negedge clk);
        req0_char = "x";
        @(negedge clk);
        checkOutput("midrst_pre_en", fsm_en, 1'b1);
        checkOutput("midrst_pre_char", fsm_char, "x");
        #2 reset_n = 1'b0;
        #1 checkAllZero("midrst");
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("midrst_no_result", res_src_q.size(), 0);

        // req0 "abcd", no stalls
        clearLog();
        applyStimulus(0, "abcd", -1, 0);
        waitResults(1);
        if (res_src_q.size() == 1 && en_cyc_q.size() == 4 && clr_cyc_q.size() == 1) begin
            checkOutput("abcd_clr_count", clr_cyc_q.size(), 1);
            checkOutput("abcd_clr_to_en", en_cyc_q[0] - clr_cyc_q[0], 2);
            checkOutput("abcd_chars", {en_char_q[0], en_char_q[1], en_char_q[2], en_char_q[3]}, "abcd");
            checkOutput("abcd_en_run", en_cyc_q[3] - en_cyc_q[0], 3);
            checkOutput("abcd_res_timing", res_cyc_q[0] - en_cyc_q[3], 1);
            checkOutput("abcd_src", res_src_q[0], 0);
            checkOutput("abcd_len", res_len_q[0], 4);
            checkOutput("abcd_match", res_match_q[0], 1);
        end else begin
            checkOutput("abcd_event_counts", {8'(res_src_q.size()), 8'(en_cyc_q.size()), 8'(clr_cyc_q.size())}, 24'h010401);
        end
        checkOutput("abcd_res_hold_len", res_len, 4);
        checkOutput("abcd_res_hold_match", res_match, 1'b1);

        // Pair from the same cycle: req0 "ab", req1 "12"
        doReset();
        clearLog();
        fork
            applyStimulus(0, "ab", -1, 0);
            applyStimulus(1, "12", -1, 0);
        join
        waitResults(2);
        if (res_src_q.size() == 2 && en_char_q.size() == 4) begin
            checkOutput("pair_first_src", res_src_q[0], 0);
            checkOutput("pair_second_src", res_src_q[1], 1);
            checkOutput("pair_len0", res_len_q[0], 2);
            checkOutput("pair_len1", res_len_q[1], 2);
            checkOutput("pair_match0", res_match_q[0], 0);
            checkOutput("pair_chars", {en_char_q[0], en_char_q[1], en_char_q[2], en_char_q[3]}, "ab12");
            checkOutput("pair_r1_after_r0", first_r1_cyc > res_cyc_q[0], 1);
        end else begin
            checkOutput("pair_event_counts", {8'(res_src_q.size()), 8'(en_char_q.size())}, 16'h0204);
        end

        // req0 re-requests three strings while req1 waits with one
        clearLog();
        fork
            begin
                applyStimulus(0, "ab", -1, 0);
                applyStimulus(0, "ab", -1, 0);
                applyStimulus(0, "ab", -1, 0);
            end
            applyStimulus(1, "12", -1, 0);
        join
        waitResults(4);
        if (res_src_q.size() == 4) begin
`ifdef CHAR_STREAM_ARB_RR_EN
            checkOutput("rr_order", {res_src_q[0][3:0], res_src_q[1][3:0], res_src_q[2][3:0], res_src_q[3][3:0]}, 16'h0100);
`else
            checkOutput("fixed_order", {res_src_q[0][3:0], res_src_q[1][3:0], res_src_q[2][3:0], res_src_q[3][3:0]}, 16'h0001);
`endif
        end

        // req1 "a%3" with valid dropped for three cycles before '3'
        clearLog();
        applyStimulus(1, "a%3", 2, 3);
        waitResults(1);
        if (res_src_q.size() == 1 && en_char_q.size() == 3) begin
            checkOutput("gap_chars", {en_char_q[0], en_char_q[1], en_char_q[2]}, "a%3");
            checkOutput("gap_spacing", en_cyc_q[2] - en_cyc_q[1], 4);
            checkOutput("gap_src", res_src_q[0], 1);
            checkOutput("gap_len", res_len_q[0], 3);
            checkOutput("gap_match", res_match_q[0], 0);
        end else begin
            checkOutput("gap_event_counts", {8'(res_src_q.size()), 8'(en_char_q.size())}, 16'h0103);
        end

        // 40-character string saturates the length counter
        clearLog();
        long_s = "";
        for (int i = 0; i < 40; i++) long_s = $sformatf("%s%c", long_s, 8'(97 + (i % 26)));
        applyStimulus(0, long_s, -1, 0);
        waitResults(1);
        checkOutput("long_en_count", en_char_q.size(), 40);
        bad = 0;
        for (int i = 0; i < en_char_q.size() && i < 40; i++) begin
            if (en_char_q[i] != 8'(97 + (i % 26))) bad++;
        end
        checkOutput("long_char_errs", bad, 0);
        if (res_src_q.size() == 1) begin
            checkOutput("long_len_sat", res_len_q[0], 31);
            checkOutput("long_match", res_match_q[0], 1);
            checkOutput("long_src", res_src_q[0], 0);
        end

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
